// File: rtl/apb_pkg.sv
// Shared types and default sizes for the APB master/slave fabric.
package apb_pkg;

  localparam int unsigned DEF_AW = 9;
  localparam int unsigned DEF_DW = 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

  typedef logic [DEF_AW-1:0] addr_t;
  typedef logic [DEF_DW-1:0] data_t;

endpackage

// File: rtl/apb_slave.sv
// Zero-wait-state APB memory slave; the whole memory clears on reset.
module apb_slave
  import apb_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          i_psel,
  input  logic          i_penable,
  input  logic          i_pwrite,
  input  logic [AW-2:0] i_paddr,
  input  logic [DW-1:0] i_pwdata,
  output logic [DW-1:0] o_prdata_c,
  output logic          o_pready_c
);

  localparam int unsigned DEPTH = 2 ** (AW - 1);

  logic [DW-1:0] r_mem [DEPTH];

  // Write commits at the edge that ends ACCESS.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_psel && i_penable && i_pwrite) begin
      r_mem[i_paddr] <= i_pwdata;
    end
  end

  assign o_prdata_c = i_psel ? r_mem[i_paddr] : '0;
  assign o_pready_c = 1'b1;

endmodule

// File: rtl/apb_modport_top.sv
// APB fabric: one master FSM driving two memory slaves selected by address MSB.
module apb_modport_top
  import apb_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          transfer,
  input  logic          read_write,
  input  logic [AW-1:0] apb_write_paddr,
  input  logic [DW-1:0] apb_write_data,
  input  logic [AW-1:0] apb_read_paddr,
  output logic [DW-1:0] apb_read_data_out
);

  apb_state_t    r_state;
  apb_state_t    w_next_state;
  logic          r_pwrite;
  logic [AW-1:0] r_paddr;
  logic [DW-1:0] r_pwdata;
  logic [DW-1:0] r_rdata;

  logic          w_latch;
  logic          w_done;
  logic          w_active;
  logic          w_sel2;
  logic          w_psel1;
  logic          w_psel2;
  logic          w_penable;
  logic          w_pready;
  logic          w_pready1;
  logic          w_pready2;
  logic [DW-1:0] w_prdata;
  logic [DW-1:0] w_prdata1;
  logic [DW-1:0] w_prdata2;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A completed ACCESS with transfer high re-latches straight into SETUP.
  always_comb begin
    w_next_state = r_state;
    w_latch      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (transfer) begin
          w_latch      = 1'b1;
          w_next_state = SETUP;
        end
      end
      SETUP: w_next_state = ACCESS;
      ACCESS: begin
        if (w_pready) begin
          w_done = 1'b1;
          if (transfer) begin
            w_latch      = 1'b1;
            w_next_state = SETUP;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else if (w_latch) begin
      r_pwrite <= ~read_write;
      r_paddr  <= read_write ? apb_read_paddr : apb_write_paddr;
      r_pwdata <= apb_write_data;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_rdata <= '0;
    end else if (w_done && !r_pwrite) begin
      r_rdata <= w_prdata;
    end
  end

  assign w_active  = (r_state == SETUP) || (r_state == ACCESS);
  assign w_sel2    = r_paddr[AW-1];
  assign w_psel1   = w_active && !w_sel2;
  assign w_psel2   = w_active && w_sel2;
  assign w_penable = (r_state == ACCESS);
  assign w_pready  = w_sel2 ? w_pready2 : w_pready1;
  assign w_prdata  = w_sel2 ? w_prdata2 : w_prdata1;

  assign apb_read_data_out = r_rdata;

  apb_slave #(.AW(AW), .DW(DW)) slave1 (
    .pclk       (pclk),
    .presetn    (presetn),
    .i_psel     (w_psel1),
    .i_penable  (w_penable),
    .i_pwrite   (r_pwrite),
    .i_paddr    (r_paddr[AW-2:0]),
    .i_pwdata   (r_pwdata),
    .o_prdata_c (w_prdata1),
    .o_pready_c (w_pready1)
  );

  apb_slave #(.AW(AW), .DW(DW)) slave2 (
    .pclk       (pclk),
    .presetn    (presetn),
    .i_psel     (w_psel2),
    .i_penable  (w_penable),
    .i_pwrite   (r_pwrite),
    .i_paddr    (r_paddr[AW-2:0]),
    .i_pwdata   (r_pwdata),
    .o_prdata_c (w_prdata2),
    .o_pready_c (w_pready2)
  );

endmodule

// File: tb/tb_apb_modport_top.sv
// Directed bench for apb_modport_top: vector table plus back-to-back and reset sequences.
module tb_apb_modport_top;
  import apb_pkg::*;

  logic       pclk;
  logic       presetn;
  logic       transfer;
  logic       read_write;
  logic [8:0] apb_write_paddr;
  logic [7:0] apb_write_data;
  logic [8:0] apb_read_paddr;
  logic [7:0] apb_read_data_out;

  int n_checks;
  int n_fail;
  logic [7:0] r_hold;

  typedef struct {
    logic       rw;
    logic [8:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [10];

  apb_modport_top dut (
    .pclk              (pclk),
    .presetn           (presetn),
    .transfer          (transfer),
    .read_write        (read_write),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_paddr    (apb_read_paddr),
    .apb_read_data_out (apb_read_data_out)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic [8:0] addr, input logic [7:0] wdata);
    read_write = rw;
    if (rw) begin
      apb_read_paddr  = addr;
      apb_write_paddr = ~addr;
    end else begin
      apb_write_paddr = addr;
      apb_read_paddr  = ~addr;
    end
    apb_write_data = wdata;
    transfer = 1'b1;
  endtask

  // Single transfer; inputs are scrambled after sampling to prove they were latched.
  task automatic xfer(input logic rw, input logic [8:0] addr, input logic [7:0] wdata,
                      input logic [7:0] exp, input string name);
    @(negedge pclk);
    drive(rw, addr, wdata);
    @(posedge pclk);
    #1;
    transfer        = 1'b0;
    read_write      = ~rw;
    apb_write_paddr = addr ^ 9'h1FF;
    apb_read_paddr  = addr ^ 9'h1FF;
    apb_write_data  = ~wdata;
    @(posedge pclk);
    #1;
    check({name, "_early"}, apb_read_data_out, r_hold);
    @(posedge pclk);
    #1;
    check(name, apb_read_data_out, exp);
    r_hold = exp;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    r_hold   = 8'h00;

    vecs[0] = '{1'b1, 9'h005, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 9'h010, 8'hA5, 8'h00};
    vecs[2] = '{1'b1, 9'h010, 8'h00, 8'hA5};
    vecs[3] = '{1'b0, 9'h110, 8'h3C, 8'hA5};
    vecs[4] = '{1'b0, 9'h010, 8'hA5, 8'hA5};
    vecs[5] = '{1'b1, 9'h110, 8'h00, 8'h3C};
    vecs[6] = '{1'b1, 9'h010, 8'h00, 8'hA5};
    vecs[7] = '{1'b0, 9'h1FF, 8'h5A, 8'hA5};
    vecs[8] = '{1'b1, 9'h0FF, 8'h00, 8'h00};
    vecs[9] = '{1'b1, 9'h1FF, 8'h00, 8'h5A};

    presetn         = 1'b0;
    transfer        = 1'b0;
    read_write      = 1'b0;
    apb_write_paddr = '0;
    apb_write_data  = '0;
    apb_read_paddr  = '0;

    // Reset: select/enable and read data low throughout.
    for (int i = 0; i < 2; i++) begin
      @(negedge pclk);
      check_bit("rst_psel1", dut.w_psel1, 1'b0);
      check_bit("rst_psel2", dut.w_psel2, 1'b0);
      check_bit("rst_penable", dut.w_penable, 1'b0);
      check("rst_rdata", apb_read_data_out, 8'h00);
    end
    presetn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      xfer(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Back-to-back: transfer stays high across four transactions.
    @(negedge pclk);
    drive(1'b0, 9'h001, 8'h11);
    @(posedge pclk);
    #1 drive(1'b0, 9'h102, 8'h22);
    @(posedge pclk);
    @(posedge pclk);
    #1 check_bit("b2b_no_idle0", dut.r_state == IDLE, 1'b0);
    drive(1'b1, 9'h001, 8'h00);
    @(posedge pclk);
    @(posedge pclk);
    #1 check_bit("b2b_no_idle1", dut.r_state == IDLE, 1'b0);
    drive(1'b1, 9'h102, 8'h00);
    @(posedge pclk);
    @(posedge pclk);
    #1 check_bit("b2b_no_idle2", dut.r_state == IDLE, 1'b0);
    check("b2b_rd1", apb_read_data_out, 8'h11);
    transfer = 1'b0;
    @(posedge pclk);
    @(posedge pclk);
    #1 check("b2b_rd2", apb_read_data_out, 8'h22);
    check_bit("b2b_idle", dut.r_state == IDLE, 1'b1);
    r_hold = 8'h22;

    // Read data holds across a write.
    xfer(1'b1, 9'h001, 8'h00, 8'h11, "hold_rd");
    xfer(1'b0, 9'h001, 8'hFF, 8'h11, "hold_wr");
    xfer(1'b1, 9'h001, 8'h00, 8'hFF, "hold_rd2");

    // Reset during the ACCESS phase of a write.
    @(negedge pclk);
    drive(1'b0, 9'h020, 8'h77);
    @(posedge pclk);
    #1 transfer = 1'b0;
    @(posedge pclk);
    #1 check_bit("mid_in_access", dut.w_penable, 1'b1);
    presetn = 1'b0;
    #1;
    check_bit("mid_psel1", dut.w_psel1, 1'b0);
    check_bit("mid_penable", dut.w_penable, 1'b0);
    check("mid_rdata", apb_read_data_out, 8'h00);
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    r_hold = 8'h00;
    xfer(1'b1, 9'h020, 8'h00, 8'h00, "mid_no_write");
    xfer(1'b1, 9'h1FF, 8'h00, 8'h00, "mid_mem_clr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
